alu_dispatch_unit: RTL and testbench
====================================

ALU_DISPATCH_UNIT -- requirements
Module: alu_dispatch_unit

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16: width of each operand.
REQ-002 SHALL have parameter ID_SIZE, default 8: width of the transaction ID.
REQ-003 SHALL have parameter OP_SIZE, default 2: width of the opcode field.
REQ-004 SHALL have parameter NUM_CH, default 2: number of functional-unit channels, 1..(2**OP_SIZE)-1.
REQ-005 SHALL have parameter ERR_CNT_SIZE, default 8: width of the error counter.
REQ-006 SHALL have localparam FIFO_W = 2*DATA_SIZE+ID_SIZE+OP_SIZE, with the FIFO word laid out as {data1, data0, id, op} and op at the LSBs.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port fifo_data, input, FIFO_W bits: the input-FIFO read data, valid the cycle after fifo_r_en.
REQ-010 SHALL have port fifo_empty, input, 1 bit: high when the input FIFO holds no entries.
REQ-011 SHALL have port fifo_r_en, output, 1 bit: single-cycle read strobe to the input FIFO.
REQ-012 SHALL have port ch_valid, output, NUM_CH bits: one-hot valid, one bit per channel.
REQ-013 SHALL have port ch_ready, input, NUM_CH bits: per-channel ready.
REQ-014 SHALL have ports opnd_0 and opnd_1, output, DATA_SIZE bits each: registered operands shared by all channels.
REQ-015 SHALL have port id_out, output, ID_SIZE bits: registered transaction ID.
REQ-016 SHALL have port illegal_op, output, 1 bit: one-cycle pulse when an opcode is rejected.
REQ-017 SHALL have port err_cnt, output, ERR_CNT_SIZE bits: saturating count of rejected opcodes.
REQ-018 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-019 SHALL implement a 3-state FSM with states IDLE, LOAD and DISPATCH.
REQ-020 In IDLE with fifo_empty=0, SHALL assert fifo_r_en combinationally for exactly one cycle and move to LOAD.
REQ-021 In LOAD, SHALL capture data0, data1 and id from fifo_data into opnd_0, opnd_1 and id_out, and decode op.
REQ-022 In LOAD, opcode k with 1<=k<=NUM_CH SHALL select channel k-1; the FSM moves to DISPATCH and ch_valid[k-1] rises on the next cycle.
REQ-023 In LOAD, opcode 0 (NOP) SHALL drop the entry without an error and return the FSM to IDLE.
REQ-024 In LOAD, opcode >NUM_CH SHALL drop the entry, pulse illegal_op in the following cycle, increment err_cnt, and return the FSM to IDLE.
REQ-025 SHALL saturate err_cnt at all-ones, with no wrap.
REQ-026 SHALL ignore fifo_empty and ch_ready while in LOAD.
REQ-027 In DISPATCH, SHALL hold ch_valid, opnd_0, opnd_1 and id_out stable until ch_ready of the selected channel is 1, ignoring ready on the other channels.
REQ-028 A handshake (valid & ready of the selected channel) SHALL clear ch_valid on the next clock edge.
REQ-029 If fifo_empty=0 in the handshake cycle, SHALL assert fifo_r_en in that same cycle and move to LOAD (back-to-back); otherwise SHALL move to IDLE.
REQ-030 SHALL sustain a peak throughput of one dispatch per 2 cycles.
REQ-031 SHALL keep at most one bit of ch_valid high at any time.
REQ-032 SHALL never assert fifo_r_en while fifo_empty=1.
REQ-033 SHALL pass operands through unmodified, with no width conversion; narrower units (e.g. the half-width multiplier) slice the LSBs themselves.

Reset
REQ-034 While rst=1, SHALL asynchronously force state=IDLE, fifo_r_en=0, ch_valid=0, opnd_0=0, opnd_1=0, id_out=0, illegal_op=0, err_cnt=0 and busy=0.
REQ-035 A reset asserted mid-transaction SHALL discard the pending entry with no handshake; the entry is not re-read.
REQ-036 After rst deasserts, the first fifo_r_en SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-037 SHALL verify single ADD: FIFO word op=1, id=0x05, data0=0x0003, data1=0x0004, ch_ready=2'b01 -> fifo_r_en at T0, ch_valid=2'b01 at T2 with opnd_0=0x0003, opnd_1=0x0004, id_out=0x05, and ch_valid cleared at T3.
REQ-038 SHALL verify backpressure: op=2, ch_ready=0 for 5 cycles then 2'b10 -> ch_valid=2'b10 and operands stable for all 6 cycles, with exactly one handshake.
REQ-039 SHALL verify back-to-back: 3 entries queued, all ready=1 -> fifo_r_en in the handshake cycles and 3 dispatches in 6 cycles.
REQ-040 SHALL verify an illegal opcode: op=3 with NUM_CH=2 -> illegal_op pulses once, err_cnt 0->1 and no ch_valid; 300 illegal entries -> err_cnt=255.
REQ-041 SHALL verify a NOP: op=0 -> no ch_valid, no illegal_op, err_cnt unchanged, and the FSM returns to IDLE.
REQ-042 SHALL verify reset in DISPATCH: rst=1 while ch_valid=2'b01 -> all outputs 0 immediately, and no fifo_r_en until rst=0.

Source files
------------

// File: rtl/alu_dispatch_unit.sv
// Pulls entries from an input FIFO, decodes the opcode and presents the operands
// to one of NUM_CH functional-unit channels over a one-hot valid/ready handshake.
module alu_dispatch_unit #(
   parameter int  DATA_SIZE    = 16,
   parameter int  ID_SIZE      = 8,
   parameter int  OP_SIZE      = 2,
   parameter int  NUM_CH       = 2,
   parameter int  ERR_CNT_SIZE = 8,
   localparam int FIFO_W       = 2*DATA_SIZE + ID_SIZE + OP_SIZE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [FIFO_W-1:0]       fifo_data,
   input  logic                    fifo_empty,
   output logic                    fifo_r_en,
   output logic [NUM_CH-1:0]       ch_valid,
   input  logic [NUM_CH-1:0]       ch_ready,
   output logic [DATA_SIZE-1:0]    opnd_0,
   output logic [DATA_SIZE-1:0]    opnd_1,
   output logic [ID_SIZE-1:0]      id_out,
   output logic                    illegal_op,
   output logic [ERR_CNT_SIZE-1:0] err_cnt,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, LOAD, DISPATCH} state_t;

   state_t                  state_q, state_d;
   logic [NUM_CH-1:0]       chValid_q, chValid_d;
   logic [DATA_SIZE-1:0]    opnd0_q, opnd0_d;
   logic [DATA_SIZE-1:0]    opnd1_q, opnd1_d;
   logic [ID_SIZE-1:0]      id_q, id_d;
   logic                    illegal_q, illegal_d;
   logic [ERR_CNT_SIZE-1:0] errCnt_q, errCnt_d;
   logic                    armed_q;
   logic                    rdEn;

   logic [OP_SIZE-1:0]      entryOp;
   logic [ID_SIZE-1:0]      entryId;
   logic [DATA_SIZE-1:0]    entryData0;
   logic [DATA_SIZE-1:0]    entryData1;
   logic [NUM_CH-1:0]       opDecoded;
   logic                    opIllegal;
   logic                    handshake;

   assign entryOp    = fifo_data[OP_SIZE-1:0];
   assign entryId    = fifo_data[OP_SIZE +: ID_SIZE];
   assign entryData0 = fifo_data[OP_SIZE+ID_SIZE +: DATA_SIZE];
   assign entryData1 = fifo_data[OP_SIZE+ID_SIZE+DATA_SIZE +: DATA_SIZE];

   // Opcode k in 1..NUM_CH selects channel k-1; 0 is a NOP and anything above NUM_CH is illegal.
   always_comb begin
      opDecoded = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (int'(entryOp) == k + 1) begin
            opDecoded[k] = 1'b1;
         end
      end
   end

   assign opIllegal = int'(entryOp) > NUM_CH;
   assign handshake = |(chValid_q & ch_ready);

   // Next-state and datapath decisions; the read strobe is the only combinational output.
   always_comb begin
      state_d   = state_q;
      chValid_d = chValid_q;
      opnd0_d   = opnd0_q;
      opnd1_d   = opnd1_q;
      id_d      = id_q;
      illegal_d = 1'b0;
      errCnt_d  = errCnt_q;
      rdEn      = 1'b0;

      case (state_q)
         IDLE: begin
            if (armed_q && !fifo_empty) begin
               rdEn    = 1'b1;
               state_d = LOAD;
            end
         end

         LOAD: begin
            opnd0_d = entryData0;
            opnd1_d = entryData1;
            id_d    = entryId;
            if (opDecoded != '0) begin
               chValid_d = opDecoded;
               state_d   = DISPATCH;
            end else begin
               if (opIllegal) begin
                  illegal_d = 1'b1;
                  if (errCnt_q != '1) begin
                     errCnt_d = errCnt_q + 1'b1;
                  end
               end
               state_d = IDLE;
            end
         end

         DISPATCH: begin
            if (handshake) begin
               chValid_d = '0;
               if (!fifo_empty) begin
                  rdEn    = 1'b1;
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            chValid_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   // armed_q holds off the first FIFO read until a clock edge has seen reset released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         chValid_q <= '0;
         opnd0_q   <= '0;
         opnd1_q   <= '0;
         id_q      <= '0;
         illegal_q <= 1'b0;
         errCnt_q  <= '0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         chValid_q <= chValid_d;
         opnd0_q   <= opnd0_d;
         opnd1_q   <= opnd1_d;
         id_q      <= id_d;
         illegal_q <= illegal_d;
         errCnt_q  <= errCnt_d;
         armed_q   <= 1'b1;
      end
   end

   assign fifo_r_en  = rdEn;
   assign ch_valid   = chValid_q;
   assign opnd_0     = opnd0_q;
   assign opnd_1     = opnd1_q;
   assign id_out     = id_q;
   assign illegal_op = illegal_q;
   assign err_cnt    = errCnt_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Self-checking bench for alu_dispatch_unit: a queue-based FIFO model feeds the DUT and a
// transaction scoreboard predicts every dispatch, illegal pulse and the saturating error count.
module tb_alu_dispatch_unit;

   localparam int DATA_SIZE    = 16;
   localparam int ID_SIZE      = 8;
   localparam int OP_SIZE      = 2;
   localparam int NUM_CH       = 2;
   localparam int ERR_CNT_SIZE = 8;
   localparam int FIFO_W       = 2*DATA_SIZE + ID_SIZE + OP_SIZE;
   localparam int BUNDLE_W     = NUM_CH + 2*DATA_SIZE + ID_SIZE;
   localparam int HIST         = 8192;
   localparam int ERR_MAX      = (1 << ERR_CNT_SIZE) - 1;

   logic                    clk;
   logic                    rst;
   logic [FIFO_W-1:0]       fifo_data;
   logic                    fifo_empty;
   logic                    fifo_r_en;
   logic [NUM_CH-1:0]       ch_valid;
   logic [NUM_CH-1:0]       ch_ready;
   logic [DATA_SIZE-1:0]    opnd_0;
   logic [DATA_SIZE-1:0]    opnd_1;
   logic [ID_SIZE-1:0]      id_out;
   logic                    illegal_op;
   logic [ERR_CNT_SIZE-1:0] err_cnt;
   logic                    busy;

   alu_dispatch_unit #(
      .DATA_SIZE(DATA_SIZE),
      .ID_SIZE(ID_SIZE),
      .OP_SIZE(OP_SIZE),
      .NUM_CH(NUM_CH),
      .ERR_CNT_SIZE(ERR_CNT_SIZE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo_data(fifo_data),
      .fifo_empty(fifo_empty),
      .fifo_r_en(fifo_r_en),
      .ch_valid(ch_valid),
      .ch_ready(ch_ready),
      .opnd_0(opnd_0),
      .opnd_1(opnd_1),
      .id_out(id_out),
      .illegal_op(illegal_op),
      .err_cnt(err_cnt),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared      = 0;
   int mismatched    = 0;
   int cycleNo       = 0;
   int illegalPushed = 0;
   int illegalSeen   = 0;

   logic [FIFO_W-1:0]   fifoQ[$];
   logic [BUNDLE_W-1:0] expQ[$];
   logic                prevValid  = 1'b0;
   logic                prevHs     = 1'b0;
   logic [BUNDLE_W-1:0] prevBundle = '0;

   logic                rdHist[HIST];
   logic [NUM_CH-1:0]   validHist[HIST];
   logic                hsHist[HIST];
   logic                illHist[HIST];
   logic                busyHist[HIST];
   logic [BUNDLE_W-1:0] bundleHist[HIST];

   // Global guard so a stuck DUT can never hang the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed time %0t, required finish before 1000000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic int h(input int c);
      return c % HIST;
   endfunction

   function automatic logic [FIFO_W-1:0] randWord();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[FIFO_W-1:0];
   endfunction

   function automatic int errExp();
      return (illegalPushed > ERR_MAX) ? ERR_MAX : illegalPushed;
   endfunction

   // Queue one FIFO entry and record what the spec says must come out of it.
   task automatic applyStimulus(input int op, input logic [ID_SIZE-1:0] id,
                                input logic [DATA_SIZE-1:0] d0, input logic [DATA_SIZE-1:0] d1);
      logic [OP_SIZE-1:0] opBits;
      opBits = OP_SIZE'(op);
      fifoQ.push_back({d1, d0, id, opBits});
      fifo_empty = 1'b0;
      if (op >= 1 && op <= NUM_CH) begin
         expQ.push_back({NUM_CH'(1) << (op - 1), d0, d1, id});
      end else if (op > NUM_CH) begin
         illegalPushed++;
      end
   endtask

   task automatic pushRandom(input int op);
      applyStimulus(op, ID_SIZE'($urandom), DATA_SIZE'($urandom), DATA_SIZE'($urandom));
   endtask

   // Per-cycle sampling at the falling edge: invariants plus the dispatch scoreboard.
   task automatic observe();
      logic                hs;
      logic [BUNDLE_W-1:0] bundle;
      int                  idx;
      bundle = {ch_valid, opnd_0, opnd_1, id_out};
      hs     = |(ch_valid & ch_ready);
      idx    = h(cycleNo);
      rdHist[idx]     = fifo_r_en;
      validHist[idx]  = ch_valid;
      hsHist[idx]     = hs;
      illHist[idx]    = illegal_op;
      busyHist[idx]   = busy;
      bundleHist[idx] = bundle;

      checkOutput("oneHotValid", 64'($countones(ch_valid) <= 1), 64'd1);
      if (fifo_r_en) checkOutput("rdWhileEmpty", 64'(fifo_empty), 64'd0);
      if (prevValid && !prevHs) checkOutput("holdOutputs", 64'(bundle), 64'(prevBundle));
      if (ch_valid != '0) checkOutput("busyWhileValid", 64'(busy), 64'd1);
      if (hs) begin
         if (expQ.size() == 0) checkOutput("spuriousDispatch", 64'(bundle), 64'd0);
         else checkOutput("dispatch", 64'(bundle), 64'(expQ.pop_front()));
      end
      if (illegal_op) illegalSeen++;
      prevValid  = (ch_valid != '0);
      prevHs     = hs;
      prevBundle = bundle;
   endtask

   // One clock: sample, let the edge happen, then answer any read like a registered FIFO.
   task automatic tick();
      logic rdSeen;
      @(negedge clk);
      observe();
      rdSeen = fifo_r_en;
      @(posedge clk);
      #1;
      if (rdSeen && fifoQ.size() != 0) fifo_data = fifoQ.pop_front();
      else fifo_data = randWord();
      fifo_empty = (fifoQ.size() == 0);
      cycleNo++;
   endtask

   task automatic drain(input logic [NUM_CH-1:0] readyVal, input int budget);
      int n = 0;
      ch_ready = readyVal;
      while ((fifoQ.size() != 0 || busy) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) checkOutput("drainTimeout", 64'(fifoQ.size()) + 64'(busy), 64'd0);
      repeat (2) tick();
   endtask

   task automatic waitValid(input logic [NUM_CH-1:0] expectValid, input int budget);
      int n = 0;
      while (ch_valid == '0 && n < budget) begin
         tick();
         n++;
      end
      checkOutput("waitValid", 64'(ch_valid), 64'(expectValid));
   endtask

   task automatic checkpoint(input string tag);
      checkOutput({tag, "ErrCnt"}, 64'(err_cnt), 64'(errExp()));
      checkOutput({tag, "IllegalPulses"}, 64'(illegalSeen), 64'(illegalPushed));
      checkOutput({tag, "PendingDispatch"}, 64'(expQ.size()), 64'd0);
      checkOutput({tag, "BusyAtRest"}, 64'(busy), 64'd0);
   endtask

   task automatic randomPhase(input int iters);
      for (int i = 0; i < iters; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            pushRandom(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) pushRandom(int'($urandom_range(0, 3)));
         end
         ch_ready = NUM_CH'($urandom);
         tick();
      end
   endtask

   initial begin
      int                  c0;
      int                  holdCnt;
      int                  hsCnt;
      logic [7:0]          pat8;
      logic [7:0]          patHs;
      logic [3:0]          pat4;
      logic [2:0]          pat3;
      logic                anyBit;
      logic [BUNDLE_W-1:0] bpBundle;

      rst        = 1'b1;
      fifo_empty = 1'b1;
      fifo_data  = '0;
      ch_ready   = '0;
      for (int i = 0; i < HIST; i++) begin
         rdHist[i]     = 1'b0;
         validHist[i]  = '0;
         hsHist[i]     = 1'b0;
         illHist[i]    = 1'b0;
         busyHist[i]   = 1'b0;
         bundleHist[i] = '0;
      end

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("resetOutputs",
                  64'({fifo_r_en, ch_valid, opnd_0, opnd_1, id_out, illegal_op, busy}), 64'd0);
      checkOutput("resetErrCnt", 64'(err_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      tick();

      // Single ADD on channel 0.
      $display("[TB] single dispatch");
      ch_ready = 2'b01;
      c0 = cycleNo;
      applyStimulus(1, 8'h05, 16'h0003, 16'h0004);
      drain(2'b01, 20);
      for (int i = 0; i < 4; i++) pat4[i] = rdHist[h(c0 + i)];
      checkOutput("addReadStrobe", 64'(pat4), 64'(4'b0001));
      checkOutput("addValidT1", 64'(validHist[h(c0 + 1)]), 64'd0);
      checkOutput("addDispatchT2", 64'(bundleHist[h(c0 + 2)]),
                  64'({2'b01, 16'h0003, 16'h0004, 8'h05}));
      checkOutput("addClearT3", 64'(validHist[h(c0 + 3)]), 64'd0);

      // Backpressure on channel 1, with ready toggling on the unselected channel.
      $display("[TB] backpressure");
      ch_ready = '0;
      applyStimulus(2, 8'hA7, 16'hBEEF, 16'h1234);
      waitValid(2'b10, 10);
      c0 = cycleNo;
      for (int i = 0; i < 5; i++) begin
         ch_ready = (i % 2 == 1) ? 2'b01 : 2'b00;
         tick();
      end
      ch_ready = 2'b10;
      tick();
      drain(2'b10, 20);
      bpBundle = {2'b10, 16'hBEEF, 16'h1234, 8'hA7};
      holdCnt  = 0;
      hsCnt    = 0;
      for (int i = 0; i < 6; i++) if (bundleHist[h(c0 + i)] == bpBundle) holdCnt++;
      for (int i = 0; i < 8; i++) if (hsHist[h(c0 + i)]) hsCnt++;
      checkOutput("bpHeldCycles", 64'(holdCnt), 64'd6);
      checkOutput("bpHandshakes", 64'(hsCnt), 64'd1);

      // Three queued entries, all channels ready: one dispatch every two cycles.
      $display("[TB] back-to-back");
      c0 = cycleNo;
      applyStimulus(1, 8'h11, 16'h1111, 16'h2222);
      applyStimulus(2, 8'h12, 16'h3333, 16'h4444);
      applyStimulus(1, 8'h13, 16'h5555, 16'h6666);
      drain(2'b11, 30);
      for (int i = 0; i < 8; i++) begin
         pat8[i]  = rdHist[h(c0 + i)];
         patHs[i] = hsHist[h(c0 + i)];
      end
      checkOutput("b2bReadStrobes", 64'(pat8), 64'(8'b0001_0101));
      checkOutput("b2bHandshakes", 64'(patHs), 64'(8'b0101_0100));
      checkOutput("b2bThirdChannel", 64'(validHist[h(c0 + 6)]), 64'(2'b01));

      // NOP: dropped quietly, FSM back to IDLE.
      $display("[TB] nop");
      c0 = cycleNo;
      applyStimulus(0, 8'h77, 16'hAAAA, 16'h5555);
      drain(2'b11, 20);
      anyBit = 1'b0;
      for (int i = 0; i < 3; i++) pat3[i] = busyHist[h(c0 + i)];
      for (int i = 0; i < 4; i++) anyBit = anyBit | (validHist[h(c0 + i)] != '0) | illHist[h(c0 + i)];
      checkOutput("nopBusyShape", 64'(pat3), 64'(3'b010));
      checkOutput("nopNoActivity", 64'(anyBit), 64'd0);
      checkpoint("nop");

      // Single illegal opcode.
      $display("[TB] illegal opcode");
      checkOutput("illegalErrBefore", 64'(err_cnt), 64'd0);
      c0 = cycleNo;
      applyStimulus(3, 8'h66, 16'h0F0F, 16'hF0F0);
      drain(2'b11, 20);
      anyBit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pat4[i] = illHist[h(c0 + i)];
         anyBit  = anyBit | (validHist[h(c0 + i)] != '0);
      end
      checkOutput("illegalPulseShape", 64'(pat4), 64'(4'b0100));
      checkOutput("illegalNoValid", 64'(anyBit), 64'd0);
      checkOutput("illegalErrAfter", 64'(err_cnt), 64'd1);
      checkpoint("illegal");

      // Randomized traffic against the scoreboard.
      $display("[TB] random traffic");
      randomPhase(300);
      drain(2'b11, 3000);
      checkpoint("random");

      // Error counter saturation.
      $display("[TB] saturation");
      for (int i = 0; i < 300; i++) pushRandom(3);
      drain(2'b11, 2000);
      checkpoint("saturate");
      checkOutput("satErrCnt", 64'(err_cnt), 64'(ERR_MAX));

      // Reset while an entry sits in DISPATCH and another waits in the FIFO.
      $display("[TB] reset in dispatch");
      ch_ready = '0;
      applyStimulus(1, 8'h3C, 16'h0101, 16'h0202);
      waitValid(2'b01, 10);
      applyStimulus(2, 8'h3D, 16'h0303, 16'h0404);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("rstAsyncOutputs",
                  64'({fifo_r_en, ch_valid, opnd_0, opnd_1, id_out, illegal_op, busy}), 64'd0);
      checkOutput("rstAsyncErrCnt", 64'(err_cnt), 64'd0);
      void'(expQ.pop_front());
      illegalPushed = 0;
      illegalSeen   = 0;
      prevValid     = 1'b0;
      prevHs        = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rdDuringReset", 64'(fifo_r_en), 64'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("rdAtRelease", 64'(fifo_r_en), 64'd0);
      drain(2'b11, 20);
      checkpoint("postReset");

      randomPhase(100);
      drain(2'b11, 2000);
      checkpoint("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
